// File: rtl/dmem_arbiter.sv
// Two-port (fetch / memory-stage) arbiter onto one single-ported 64-bit data memory.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (out-of-range addresses complete with rdata=0 and m_err).
module dmem_arbiter #(
  parameter int unsigned MEM_WORDS  = 8192,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req_i,
  input  logic [63:0] f_addr_i,
  output logic        f_gnt_o,
  output logic        f_valid_o,
  output logic [63:0] f_rdata_o,
  input  logic        m_req_i,
  input  logic        m_we_i,
  input  logic [63:0] m_addr_i,
  input  logic [63:0] m_wdata_i,
  output logic        m_gnt_o,
  output logic        m_valid_o,
  output logic [63:0] m_rdata_o,
  output logic        m_err_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [12:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic [63:0] mem_rdata_i,
  output logic [1:0]  dbg_state_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_M = 2'd2
  } state_e;

  state_e        state_q;
  logic [SW-1:0] starve_q;
  logic          mem_re_q, mem_we_q;
  logic [12:0]   mem_addr_q;
  logic [63:0]   mem_wdata_q;
  logic          rd_ok_q, err_q;
  logic          f_valid_q, m_valid_q;
  logic [63:0]   f_hold_q, m_hold_q;

  logic idle, starved, f_win, m_win, f_oob, m_oob;

  // Requesters hold req until they see gnt in the same cycle; gnt is combinational
  // and only ever raised in IDLE, so a request seen during BUSY simply waits.
  assign idle    = (state_q == IDLE);
  assign starved = (starve_q == SW'(STARVE_MAX));
  assign f_win   = rst_n && idle && f_req_i && (!m_req_i || starved);
  assign m_win   = rst_n && idle && m_req_i && !f_win;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign f_oob   = (f_addr_i >= 64'(MEM_WORDS));
  assign m_oob   = (m_addr_i >= 64'(MEM_WORDS));
  assign m_err_o = m_valid_q & err_q;
`else
  logic unused_bits;
  assign f_oob       = 1'b0;
  assign m_oob       = 1'b0;
  assign m_err_o     = 1'b0;
  assign unused_bits = ^{f_addr_i[63:13], m_addr_i[63:13], err_q, 32'(MEM_WORDS)};
`endif

  assign f_gnt_o     = f_win;
  assign m_gnt_o     = m_win;
  assign f_valid_o   = f_valid_q;
  assign m_valid_o   = m_valid_q;
  assign mem_re_o    = mem_re_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign dbg_state_o = state_q;

  // Read data arrives the cycle after the strobe, i.e. in the valid cycle itself.
  assign f_rdata_o = f_valid_q ? (rd_ok_q ? mem_rdata_i : 64'd0) : f_hold_q;
  assign m_rdata_o = m_valid_q ? (rd_ok_q ? mem_rdata_i : 64'd0) : m_hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_ok_q     <= 1'b0;
      err_q       <= 1'b0;
      f_valid_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      f_hold_q    <= '0;
      m_hold_q    <= '0;
    end else begin
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      f_valid_q <= 1'b0;
      m_valid_q <= 1'b0;
      if (f_valid_q) f_hold_q <= f_rdata_o;
      if (m_valid_q) m_hold_q <= m_rdata_o;

      if (!f_req_i || f_win) starve_q <= '0;
      else if (m_win && !starved) starve_q <= starve_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (f_win) begin
            state_q     <= BUSY_F;
            mem_re_q    <= !f_oob;
            mem_addr_q  <= f_addr_i[12:0];
            mem_wdata_q <= '0;
            rd_ok_q     <= !f_oob;
            err_q       <= f_oob;
          end else if (m_win) begin
            state_q     <= BUSY_M;
            mem_re_q    <= !m_we_i && !m_oob;
            mem_we_q    <= m_we_i && !m_oob;
            mem_addr_q  <= m_addr_i[12:0];
            mem_wdata_q <= m_wdata_i;
            rd_ok_q     <= !m_we_i && !m_oob;
            err_q       <= m_oob;
          end
        end
        BUSY_F: begin
          state_q   <= IDLE;
          f_valid_q <= 1'b1;
        end
        BUSY_M: begin
          state_q   <= IDLE;
          m_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
